// File: rtl/stream_boxcar_decim.sv
// Boxcar-averaging decimator for packetised signed sample streams.
// Averages 2^decim_log2 input beats into one output beat and keeps packet framing.
module stream_boxcar_decim #(
    parameter int DATA_WIDTH     = 16,
    parameter int DECIM_LOG2_MAX = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [3:0]            decim_log2,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready
);

    // state | meaning
    // FIRST | waiting for the first beat of a packet, latches the decimation exponent
    // ACCUM | summing the remaining beats of the packet block by block
    typedef enum logic {S_FIRST, S_ACCUM} state_t;

    localparam int AW = DATA_WIDTH + DECIM_LOG2_MAX;
    localparam int CW = DECIM_LOG2_MAX + 1;
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    DL_MAX = 4'(DECIM_LOG2_MAX);

    state_t                r_state;
    logic [3:0]            r_dl;
    logic signed [AW-1:0]  r_acc;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;

    logic                  w_in_beat;
    logic [3:0]            w_dl_new;
    logic [3:0]            w_dl_eff;
    logic signed [AW-1:0]  w_sext;
    logic signed [AW-1:0]  w_sum;
    logic [CW-1:0]         w_count_next;
    logic [CW-1:0]         w_block_len;
    logic                  w_complete;
    logic                  w_emit;

    assign s_tready  = !r_m_tvalid | m_tready;
    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;

    assign w_in_beat    = s_tvalid & s_tready;
    assign w_dl_new     = (decim_log2 > DL_MAX) ? DL_MAX : decim_log2;
    assign w_dl_eff     = (r_state == S_FIRST) ? w_dl_new : r_dl;
    assign w_sext       = {{DECIM_LOG2_MAX{s_tdata[DATA_WIDTH-1]}}, s_tdata};
    assign w_sum        = (r_state == S_FIRST) ? w_sext : (r_acc + w_sext);
    assign w_count_next = (r_state == S_FIRST) ? ONE : (r_count + ONE);
    assign w_block_len  = ONE << r_dl;
    // The block length compare uses only the exponent latched at packet start
    assign w_complete   = s_tlast | ((r_state == S_FIRST) ? (w_dl_new == 4'd0)
                                                          : (w_count_next == w_block_len));
    assign w_emit       = w_in_beat & w_complete;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_FIRST;
            r_dl       <= 4'd0;
            r_acc      <= '0;
            r_count    <= '0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else begin
            if (w_emit) begin
                r_m_tdata  <= DATA_WIDTH'(w_sum >>> w_dl_eff);
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= s_tlast;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_in_beat) begin
                case (r_state)
                    S_FIRST: begin
                        r_dl    <= w_dl_new;
                        r_acc   <= w_sum;
                        r_count <= w_count_next;
                        r_state <= w_complete ? S_FIRST : S_ACCUM;
                    end
                    S_ACCUM: begin
                        if (w_emit && s_tlast) begin
                            r_acc   <= w_sum;
                            r_count <= w_count_next;
                            r_state <= S_FIRST;
                        end else if (w_emit) begin
                            r_acc   <= '0;
                            r_count <= '0;
                        end else begin
                            r_acc   <= w_sum;
                            r_count <= w_count_next;
                        end
                    end
                    default: r_state <= S_FIRST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_boxcar_decim.sv
// Self-checking bench for stream_boxcar_decim: vector table, hand sequences and a
// randomised run, all scored through an expected-output queue.
module tb_stream_boxcar_decim;

    logic        clk;
    logic        resetn;
    logic [3:0]  decim_log2;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    stream_boxcar_decim #(.DATA_WIDTH(16), .DECIM_LOG2_MAX(8)) dut (
        .clk(clk), .resetn(resetn), .decim_log2(decim_log2),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]        dl;
        logic [3:0]        n;
        logic [7:0][15:0]  d;
        logic [3:0]        ne;
        logic [7:0][15:0]  e;
    } vec_t;

    vec_t        tbl[8];
    logic [16:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          use_model = 1'b0;
    bit          rand_ready = 1'b0;

    // reference model state
    bit          m_first = 1'b1;
    int          m_dl = 0;
    int          m_sum = 0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_beat(input logic [15:0] d, input logic l);
        int x;
        bit done;
        x = int'($signed(d));
        if (m_first) begin
            m_dl  = (decim_log2 > 4'd8) ? 8 : int'(decim_log2);
            m_sum = x;
            m_cnt = 1;
        end else begin
            m_sum = m_sum + x;
            m_cnt = m_cnt + 1;
        end
        done = l || (m_cnt == (1 << m_dl));
        if (done) begin
            exp_q.push_back({l, 16'(m_sum >>> m_dl)});
            if (l) m_first = 1'b1;
            else if (m_first) m_first = 1'b1;
            else begin
                m_sum = 0;
                m_cnt = 0;
            end
        end else begin
            m_first = 1'b0;
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l, output int waits);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!s_tready && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_tready stuck at 0, required 1");
        end else if (use_model) begin
            model_beat(d, l);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard: pop on every output beat
    always @(negedge clk) begin
        if (resetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %0h last %0b, required no output", m_tdata, m_tlast);
            end else begin
                chk("out_beat", {15'd0, m_tlast, m_tdata}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int w;
        int bl;
        bit cpl;

        tbl[0] = '{dl:4'd2, n:4'd8, d:{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                   ne:4'd2, e:{96'd0, 16'd6, 16'd2}};
        tbl[1] = '{dl:4'd2, n:4'd6, d:{32'd0, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                   ne:4'd2, e:{96'd0, 16'd2, 16'd2}};
        tbl[2] = '{dl:4'd2, n:4'd4, d:{64'd0, 16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF},
                   ne:4'd1, e:{112'd0, 16'hFFFD}};
        tbl[3] = '{dl:4'd2, n:4'd4, d:{64'd0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                   ne:4'd1, e:{112'd0, 16'h7FFF}};
        tbl[4] = '{dl:4'd2, n:4'd4, d:{64'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000},
                   ne:4'd1, e:{112'd0, 16'h8000}};
        tbl[5] = '{dl:4'd0, n:4'd5, d:{48'd0, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10},
                   ne:4'd5, e:{48'd0, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10}};
        tbl[6] = '{dl:4'd3, n:4'd8, d:{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                   ne:4'd1, e:{112'd0, 16'd4}};
        tbl[7] = '{dl:4'd1, n:4'd3, d:{80'd0, 16'd7, 16'd6, 16'd5},
                   ne:4'd2, e:{96'd0, 16'd3, 16'd5}};

        resetn     = 1'b0;
        decim_log2 = 4'd2;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;
        idle(3);
        chk("reset_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("reset_tlast", {31'd0, m_tlast}, 32'd0);
        chk("reset_tdata", {16'd0, m_tdata}, 32'd0);
        chk("reset_tready", {31'd0, s_tready}, 32'd1);
        resetn = 1'b1;
        idle(1);

        // table-driven vectors, expected outputs from the table
        for (int v = 0; v < 8; v++) begin
            decim_log2 = tbl[v].dl;
            bl = 1 << int'(tbl[v].dl);
            for (int j = 0; j < int'(tbl[v].ne); j++)
                exp_q.push_back({(j == int'(tbl[v].ne) - 1), tbl[v].e[j]});
            for (int i = 0; i < int'(tbl[v].n); i++) begin
                send_beat(tbl[v].d[i], (i == int'(tbl[v].n) - 1), w);
                chk("no_stall", w, 0);
                cpl = ((i + 1) % bl == 0) || (i == int'(tbl[v].n) - 1);
                chk("latency_valid", {31'd0, m_tvalid}, {31'd0, cpl});
            end
            idle(2);
        end

        use_model = 1'b1;

        // reset after 3 of 4 samples discards the partial sum
        decim_log2 = 4'd2;
        send_beat(16'd1, 1'b0, w);
        send_beat(16'd2, 1'b0, w);
        send_beat(16'd3, 1'b0, w);
        resetn = 1'b0;
        idle(1);
        resetn  = 1'b1;
        m_first = 1'b1;
        chk("midreset_tvalid", {31'd0, m_tvalid}, 32'd0);
        idle(2);
        chk("midreset_no_out", {31'd0, m_tvalid}, 32'd0);
        send_beat(16'd4, 1'b0, w);
        send_beat(16'd8, 1'b0, w);
        send_beat(16'd12, 1'b0, w);
        send_beat(16'd16, 1'b1, w);
        chk("post_reset_data", {16'd0, m_tdata}, 32'd10);
        idle(2);

        // decim_log2 change mid-packet has no effect until the next packet
        decim_log2 = 4'd2;
        send_beat(16'd1, 1'b0, w);
        decim_log2 = 4'd0;
        for (int i = 2; i <= 8; i++) send_beat(16'(i), (i == 8), w);
        chk("midchange_data", {16'd0, m_tdata}, 32'd6);
        idle(2);

        // exponent above the maximum behaves as 8
        decim_log2 = 4'd15;
        for (int i = 0; i < 512; i++) begin
            send_beat((i < 256) ? 16'd3 : 16'd5, (i == 511), w);
            if (i == 255) chk("clamp_block_valid", {31'd0, m_tvalid}, 32'd1);
        end
        chk("clamp_last_data", {16'd0, m_tdata}, 32'd5);
        idle(2);

        // backpressure: held output, input stalled, nothing lost
        decim_log2 = 4'd2;
        m_tready   = 1'b0;
        send_beat(16'd100, 1'b0, w);
        send_beat(16'd200, 1'b0, w);
        send_beat(16'd300, 1'b0, w);
        send_beat(16'd400, 1'b0, w);
        s_tdata  = 16'd500;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_tready", {31'd0, s_tready}, 32'd0);
            chk("bp_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("bp_tdata", {16'd0, m_tdata}, 32'd250);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        send_beat(16'd500, 1'b0, w);
        send_beat(16'd600, 1'b0, w);
        send_beat(16'd700, 1'b0, w);
        send_beat(16'd800, 1'b1, w);
        chk("bp_second_data", {16'd0, m_tdata}, 32'd650);
        idle(2);

        // random packets against the model with random output ready
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 12);
            decim_log2 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                                      : 4'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                send_beat(16'($urandom), (i == len - 1), w);
                idle($urandom_range(0, 2));
            end
        end
        rand_ready = 1'b0;
        m_tready   = 1'b1;

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
